tt_sel_seq: RTL and testbench

- Selection sequencer inside the controller domain; owns the 10-bit design address driven onto the vertical spine, plus the user-design enable/reset handshake.
- Consumes the three control-high pad inputs (select reset, select increment, global enable) asynchronously and synchronises them.
- Sequences every address change through blank -> user-reset -> run, so branch muxes never expose a half-switched design.

---
 rtl/tt_ctrl_pkg.sv | 15 +
 rtl/tt_sync_edge.sv | 28 ++
 rtl/tt_sel_seq.sv | 135 +++++++++++++
 tb/tb_tt_sel_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tt_ctrl_pkg.sv
// Shared controller-domain types: sequencer FSM states and spine address field widths.
package tt_ctrl_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned BRANCH_W = 5;
    localparam int unsigned SLOT_W   = 5;

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StBlank = 2'd1,
        StUrst  = 2'd2,
        StRun   = 2'd3
    } tt_state_e;

endpackage

// File: rtl/tt_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pad input, with a registered copy for rise detect.
module tt_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tt_sel_seq.sv
// Selection sequencer: owns the spine design address and steps every address change
// through blank -> user-reset -> run so the branch muxes never expose a half-switched design.
module tt_sel_seq
    import tt_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned N_BRANCH    = 24,
    parameter int unsigned BLANK_CYC   = 4,
    parameter int unsigned URST_CYC    = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pad_sel_rst_ni,
    input  logic              pad_sel_inc_i,
    input  logic              pad_ena_i,
    output logic [ADDR_W-1:0] sel_o,
    output logic              sel_valid_o,
    output logic              um_ena_o,
    output logic              um_rst_no,
    output logic              busy_o
);

    localparam logic [7:0] BlankLoad = 8'(BLANK_CYC - 1);
    localparam logic [7:0] UrstLoad  = 8'(URST_CYC - 1);

    logic sel_rst_n_s, sel_rst_rise_unused;
    logic inc_s_unused, inc_rise;
    logic ena_s, ena_rise_unused;

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel_rst (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pad_sel_rst_ni),
        .level_o(sel_rst_n_s),
        .rise_o (sel_rst_rise_unused)
    );

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pad_sel_inc_i),
        .level_o(inc_s_unused),
        .rise_o (inc_rise)
    );

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ena (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pad_ena_i),
        .level_o(ena_s),
        .rise_o (ena_rise_unused)
    );

    logic [ADDR_W-1:0] sel_q, sel_d;
    logic              sel_valid_q, sel_valid_d;
    logic              change;
    tt_state_e         state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              um_ena_q, um_rst_n_q, busy_q;

    always_comb begin
        sel_d = sel_q;
        if (!sel_rst_n_s) begin
            sel_d = '0;
        end else if (inc_rise) begin
            sel_d = sel_q + ADDR_W'(1);
        end
        sel_valid_d = 32'(sel_d[ADDR_W-1:SLOT_W]) < N_BRANCH;
        change      = (sel_d != sel_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StOff) begin
            if (ena_s && sel_valid_d) begin
                state_d = StBlank;
                cnt_d   = BlankLoad;
            end
        end else if (!ena_s || !sel_valid_d) begin
            state_d = StOff;
        end else if (change) begin
            // Any address move restarts the whole blank/reset sequence.
            state_d = StBlank;
            cnt_d   = BlankLoad;
        end else begin
            unique case (state_q)
                StBlank: begin
                    if (cnt_q == 8'd0) begin
                        state_d = StUrst;
                        cnt_d   = UrstLoad;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                StUrst: begin
                    if (cnt_q == 8'd0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q       <= '0;
            sel_valid_q <= 1'b1;
            state_q     <= StOff;
            cnt_q       <= 8'd0;
            um_ena_q    <= 1'b0;
            um_rst_n_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            // Decoded from next state so the spine controls come straight off flops.
            um_ena_q    <= (state_d == StUrst) || (state_d == StRun);
            um_rst_n_q  <= (state_d == StRun);
            busy_q      <= (state_d == StBlank) || (state_d == StUrst);
        end
    end

    assign sel_o       = sel_q;
    assign sel_valid_o = sel_valid_q;
    assign um_ena_o    = um_ena_q;
    assign um_rst_no   = um_rst_n_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Directed bench for tt_sel_seq with hand-computed expectations and immediate assertions.
module tb_tt_sel_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       pad_sel_rst_ni;
    logic       pad_sel_inc_i;
    logic       pad_ena_i;
    logic [9:0] sel_o;
    logic       sel_valid_o;
    logic       um_ena_o;
    logic       um_rst_no;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    tt_sel_seq dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pad_sel_rst_ni(pad_sel_rst_ni),
        .pad_sel_inc_i (pad_sel_inc_i),
        .pad_ena_i     (pad_ena_i),
        .sel_o         (sel_o),
        .sel_valid_o   (sel_valid_o),
        .um_ena_o      (um_ena_o),
        .um_rst_no     (um_rst_no),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pad high for three edges: the increment lands on the third, then one low cycle.
    task automatic pulse();
        pad_sel_inc_i = 1'b1;
        tick(3);
        pad_sel_inc_i = 1'b0;
        tick(1);
    endtask

    initial begin
        int exp_sel;
        rst_ni         = 1'b0;
        pad_sel_rst_ni = 1'b1;
        pad_sel_inc_i  = 1'b0;
        pad_ena_i      = 1'b0;
        tick(2);
        check("rst_sel", 32'(sel_o), 0);
        check("rst_valid", 32'(sel_valid_o), 1);
        check("rst_um_ena", 32'(um_ena_o), 0);
        check("rst_um_rst_n", 32'(um_rst_no), 0);
        check("rst_busy", 32'(busy_o), 0);
        rst_ni = 1'b1;
        tick(4);

        // Enable at sel=0: BLANK entry 3 edges after pad, um_ena at +4, um_rst_n at +12.
        pad_ena_i = 1'b1;
        tick(2);
        check("en_pre_busy", 32'(busy_o), 0);
        tick(1);
        check("en_c0_busy", 32'(busy_o), 1);
        check("en_c0_um_ena", 32'(um_ena_o), 0);
        tick(3);
        check("en_c3_um_ena", 32'(um_ena_o), 0);
        tick(1);
        check("en_c4_um_ena", 32'(um_ena_o), 1);
        check("en_c4_um_rst_n", 32'(um_rst_no), 0);
        tick(7);
        check("en_c11_um_rst_n", 32'(um_rst_no), 0);
        check("en_c11_busy", 32'(busy_o), 1);
        tick(1);
        check("en_c12_um_rst_n", 32'(um_rst_no), 1);
        check("en_c12_um_ena", 32'(um_ena_o), 1);
        check("en_c12_busy", 32'(busy_o), 0);

        // Five increments in RUN, each restarting BLANK.
        for (int i = 1; i <= 5; i++) begin
            pad_sel_inc_i = 1'b1;
            tick(3);
            check("inc_sel", 32'(sel_o), 32'(i));
            check("inc_um_ena_drop", 32'(um_ena_o), 0);
            check("inc_busy", 32'(busy_o), 1);
            pad_sel_inc_i = 1'b0;
            tick(2);
        end
        tick(9);
        check("inc_c11_um_rst_n", 32'(um_rst_no), 0);
        tick(1);
        check("inc_c12_um_rst_n", 32'(um_rst_no), 1);
        check("inc_c12_sel", 32'(sel_o), 5);

        // Walk up to the first invalid branch.
        for (int i = 6; i <= 767; i++) pulse();
        check("b767_sel", 32'(sel_o), 767);
        check("b767_valid", 32'(sel_valid_o), 1);
        pad_sel_inc_i = 1'b1;
        tick(3);
        check("b768_sel", 32'(sel_o), 768);
        check("b768_valid", 32'(sel_valid_o), 0);
        check("b768_um_ena", 32'(um_ena_o), 0);
        check("b768_busy", 32'(busy_o), 0);
        pad_sel_inc_i = 1'b0;
        tick(1);
        pulse();
        check("b769_sel", 32'(sel_o), 769);
        check("b769_valid", 32'(sel_valid_o), 0);
        check("b769_busy", 32'(busy_o), 0);
        check("b769_um_rst_n", 32'(um_rst_no), 0);

        // Select reset clears the address and restarts; incs are masked while it is held.
        pad_sel_rst_ni = 1'b0;
        tick(3);
        check("srst_sel", 32'(sel_o), 0);
        check("srst_valid", 32'(sel_valid_o), 1);
        check("srst_busy", 32'(busy_o), 1);
        pulse();
        check("srst_mask_sel", 32'(sel_o), 0);
        pad_sel_rst_ni = 1'b1;
        tick(3);

        // Full wrap through 1024 increments.
        exp_sel = 0;
        for (int i = 0; i < 1024; i++) begin
            pulse();
            exp_sel = (exp_sel + 1) % 1024;
            check("wrap_sel", 32'(sel_o), 32'(exp_sel));
            check("wrap_valid", 32'(sel_valid_o), ((exp_sel / 32) < 24) ? 1 : 0);
        end

        // Enable dropped mid-URST.
        tick(11);
        check("w_run_um_rst_n", 32'(um_rst_no), 1);
        pulse();
        tick(3);
        check("ur_c4_um_ena", 32'(um_ena_o), 1);
        tick(2);
        pad_ena_i = 1'b0;
        tick(2);
        check("ur_c8_um_ena", 32'(um_ena_o), 1);
        check("ur_c8_busy", 32'(busy_o), 1);
        tick(1);
        check("ur_off_um_ena", 32'(um_ena_o), 0);
        check("ur_off_um_rst_n", 32'(um_rst_no), 0);
        check("ur_off_busy", 32'(busy_o), 0);

        // Asynchronous reset in RUN with sel=37.
        pad_ena_i = 1'b1;
        for (int i = 0; i < 36; i++) pulse();
        tick(11);
        check("ar_pre_sel", 32'(sel_o), 37);
        check("ar_pre_um_rst_n", 32'(um_rst_no), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_sel", 32'(sel_o), 0);
        check("ar_valid", 32'(sel_valid_o), 1);
        check("ar_um_ena", 32'(um_ena_o), 0);
        check("ar_um_rst_n", 32'(um_rst_no), 0);
        check("ar_busy", 32'(busy_o), 0);
        tick(2);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick(2);
        check("ar_r2_busy", 32'(busy_o), 0);
        tick(1);
        check("ar_r3_busy", 32'(busy_o), 1);
        check("ar_r3_um_ena", 32'(um_ena_o), 0);
        tick(4);
        check("ar_r7_um_ena", 32'(um_ena_o), 1);
        check("ar_r7_sel", 32'(sel_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
